alu_issue_ctrl: RTL

//  Initiator side of the 8-bit ALU interface. Accepts one command per valid/ready handshake.

---
 rtl/alu_issue_ctrl_pkg.sv | 46 ++++
 rtl/alu_issue_ctrl_cond.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcode, ALU select, branch condition and FSM encodings for alu_issue_ctrl.
// Pure declarations; no latency.
// No flow control of its own.
package alu_issue_ctrl_pkg;

  localparam logic [2:0] OP_SHL = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_BRC = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam logic [1:0] SEL_SHL = 2'b00;
  localparam logic [1:0] SEL_SHR = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;
  localparam logic [1:0] SEL_SUB = 2'b11;

  localparam logic [2:0] CC_AL = 3'd0;
  localparam logic [2:0] CC_Z  = 3'd1;
  localparam logic [2:0] CC_NZ = 3'd2;
  localparam logic [2:0] CC_C  = 3'd3;
  localparam logic [2:0] CC_NC = 3'd4;
  localparam logic [2:0] CC_N  = 3'd5;
  localparam logic [2:0] CC_V  = 3'd6;
  localparam logic [2:0] CC_LT = 3'd7;

  // Bit positions inside the {C,V,N,Z} flag register.
  localparam int FL_C = 3;
  localparam int FL_V = 2;
  localparam int FL_N = 1;
  localparam int FL_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Opcodes 0..4 are the ones that use the external ALU.
  function automatic logic uses_alu(input logic [2:0] op);
    return (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond.sv
// Branch condition evaluator: stored {C,V,N,Z} flags and a 3-bit condition code -> taken.
// Purely combinational, zero latency.
// No backpressure.
module alu_cond_eval
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cc,
  output logic       taken
);

  // Decode the condition code against the flag bits.
  always_comb begin
    taken = 1'b0;
    case (cc)
      CC_AL:   taken = 1'b1;
      CC_Z:    taken = flags[FL_Z];
      CC_NZ:   taken = ~flags[FL_Z];
      CC_C:    taken = flags[FL_C];
      CC_NC:   taken = ~flags[FL_C];
      CC_N:    taken = flags[FL_N];
      CC_V:    taken = flags[FL_V];
      CC_LT:   taken = flags[FL_N] ^ flags[FL_V];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues commands to an external 8-bit ALU, writes back results/flags, answers with a response.
// Accept-to-rsp_valid is 2 cycles; at most one command every 3 cycles.
// cmd_ready only in IDLE; the response is held stable until rsp_ready.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [AW-1:0]     cmd_rd,
  input  logic [AW-1:0]     cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_select,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_flags,
  output logic              rsp_br_taken,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [3:0]          flags;
  logic [2:0]          op;
  logic [AW-1:0]       rd, rs;
  logic [DATA_W-1:0]   imm;
  logic                br_taken;

  alu_cond_eval u_cond (
    .flags (flags),
    .cc    (imm[2:0]),
    .taken (br_taken)
  );

  assign dbg_data  = regs[dbg_addr];
  assign rsp_flags = flags;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake outputs and ALU operand drive.
  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_select = SEL_SHL;
    case (state)
      ST_IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (uses_alu(op)) begin
          alu_a      = regs[rd];
          alu_b      = regs[rs];
          alu_select = (op == OP_CMP) ? SEL_SUB : op[1:0];
        end
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, write-back, flag update and response capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flags        <= '0;
      op           <= OP_NOP;
      rd           <= '0;
      rs           <= '0;
      imm          <= '0;
      rsp_data     <= '0;
      rsp_br_taken <= 1'b0;
    end else begin
      if (state == ST_IDLE && cmd_valid) begin
        op  <= cmd_op;
        rd  <= cmd_rd;
        rs  <= cmd_rs;
        imm <= cmd_imm;
      end
      if (state == ST_EXEC) begin
        rsp_br_taken <= 1'b0;
        rsp_data     <= '0;
        case (op)
          OP_SHL, OP_SHR, OP_ADD, OP_SUB: begin
            regs[rd] <= alu_result;
            flags    <= {alu_carry, alu_overflow, alu_negative, alu_zero};
            rsp_data <= alu_result;
          end
          OP_CMP: begin
            flags    <= {alu_carry, alu_overflow, alu_negative, alu_zero};
            rsp_data <= alu_result;
          end
          OP_LDI: begin
            regs[rd] <= imm;
            rsp_data <= imm;
          end
          OP_BRC:  rsp_br_taken <= br_taken;
          default: ;
        endcase
      end
    end
  end

endmodule
